// File: rtl/cdc_sync_pkg.sv
// Shared limits, defaults and derived widths for the command_en clock-domain synchronizer.
package cdc_sync_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int CNT_W_DEF         = 16;
  localparam int FILTER_CYCLES_DEF = 4;

  // The filter counter must be able to hold the values 0..FILTER_CYCLES.
  function automatic int filt_cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// N-stage flip-flop synchronizer with asynchronous active-high reset.
// Exposes the last stage and the stage feeding it, so callers can compute registered edge pulses.
module sync_ff_chain
  import cdc_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync_nxt,
  output logic sync_q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign sync_nxt = stage_q[SYNC_STAGES-2];
  assign sync_q   = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_command_sync.sv
// Synchronizes the slow-domain level command_en into clk_fast, with edge pulses and a rise counter.
// Optional glitch filter enabled by defining CDC_SYNC_FILTER_EN.
module cdc_command_sync
  import cdc_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic             clk_fast,
  input  logic             rst_fast,
  input  logic             command_en,
  output logic             command_en_sync,
  output logic             command_rise,
  output logic             command_fall,
  output logic [CNT_W-1:0] rise_count
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("cdc_command_sync: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic sync_nxt;
  logic sync_q;
  logic level_q;
  logic level_d;
  logic rise_p1;
  logic fall_p1;
  logic [CNT_W-1:0] cnt_p2;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk_fast),
    .rst      (rst_fast),
    .d        (command_en),
    .sync_nxt (sync_nxt),
    .sync_q   (sync_q)
  );

`ifdef CDC_SYNC_FILTER_EN
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("cdc_command_sync: FILTER_CYCLES=%0d must be >= 1", FILTER_CYCLES);
  end

  localparam int FCW = filt_cnt_w(FILTER_CYCLES);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

  logic [FCW-1:0] filt_cnt;
  logic           differ;
  logic           accept;
  logic           unused_sync_nxt;

  assign unused_sync_nxt = sync_nxt;
  assign differ  = sync_q ^ level_q;
  // Accept on the cycle that completes FILTER_CYCLES consecutive differing samples.
  assign accept  = differ && (filt_cnt == FILT_LAST);
  assign level_d = accept ? sync_q : level_q;

  // Filter stage
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      filt_cnt <= '0;
      level_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      if (!differ || accept) begin
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end
`else
  localparam int UNUSED_FILTER_CYCLES = FILTER_CYCLES;

  // The last synchronizer stage is the level; the stage before it is its next value.
  assign level_q = sync_q;
  assign level_d = sync_nxt;
`endif

  // Edge detect stage: pulses land in the same cycle the level changes
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      rise_p1 <= level_d & ~level_q;
      fall_p1 <= ~level_d & level_q;
    end
  end

  // Counter stage: counts each rise pulse one cycle later, wrapping freely
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      cnt_p2 <= '0;
    end else begin
      cnt_p2 <= cnt_p2 + {{(CNT_W-1){1'b0}}, rise_p1};
    end
  end

  assign command_en_sync = level_q;
  assign command_rise    = rise_p1;
  assign command_fall    = fall_p1;
  assign rise_count      = cnt_p2;

endmodule

// File: tb/tb_cdc_command_sync.sv
// Bench for cdc_command_sync: directed scenarios plus randomized levels checked against a
// history-based reference model every cycle. Build with and without CDC_SYNC_FILTER_EN.
`timescale 1ns/1ps
module tb_cdc_command_sync;

  localparam int N  = 2;
  localparam int F  = 4;
  localparam int CW = 4;
`ifdef CDC_SYNC_FILTER_EN
  localparam int LAT     = N + F;
  localparam bit FILT_ON = 1'b1;
`else
  localparam int LAT     = N;
  localparam bit FILT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sync_o;
  logic          rise_o;
  logic          fall_o;
  logic [CW-1:0] cnt_o;

  always #2.5 clk = ~clk;

  cdc_command_sync #(
    .SYNC_STAGES   (N),
    .CNT_W         (CW),
    .FILTER_CYCLES (F)
  ) dut (
    .clk_fast        (clk),
    .rst_fast        (rst),
    .command_en      (en),
    .command_en_sync (sync_o),
    .command_rise    (rise_o),
    .command_fall    (fall_o),
    .rise_count      (cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $realtime, act, exp);
    end
  endtask

  task automatic at(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Reference model: full history of command_en as sampled at each edge since reset release.
  bit            samp[$];
  bit            e_sync;
  bit            e_rise;
  bit            e_fall;
  logic [CW-1:0] e_cnt;

  // Synchronized (unfiltered) level after edge j: the sample taken N-1 edges earlier.
  function automatic bit raw_at(input int j);
    if (j - N + 1 < 0) return 1'b0;
    return samp[j - N + 1];
  endfunction

  always @(posedge clk or posedge rst) begin
    int k;
    bit nxt;
    bit diff_all;
    if (rst) begin
      samp.delete();
      e_sync <= 1'b0;
      e_rise <= 1'b0;
      e_fall <= 1'b0;
      e_cnt  <= '0;
    end else begin
      samp.push_back(en);
      k = samp.size() - 1;
      if (FILT_ON) begin
        // Output flips only when the last F synchronized values all disagree with it.
        diff_all = 1'b1;
        for (int i = 1; i <= F; i++) begin
          if (raw_at(k - i) == e_sync) diff_all = 1'b0;
        end
        nxt = diff_all ? raw_at(k - 1) : e_sync;
      end else begin
        nxt = raw_at(k);
      end
      e_rise <= nxt & ~e_sync;
      e_fall <= ~nxt & e_sync;
      e_sync <= nxt;
      e_cnt  <= e_cnt + CW'(e_rise);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_sync", sync_o, e_sync);
      chk("model_rise", rise_o, e_rise);
      chk("model_fall", fall_o, e_fall);
      chk("model_cnt",  cnt_o,  e_cnt);
    end
  end

  // Change command_en at t_chg and pin the output edge timing and the counter by hand.
  task automatic edge_check(input realtime t_chg, input bit lvl, input string tag,
                            input int cnt_exp);
    realtime fe;
    realtime oe;
    fe = 2.5;
    while (fe <= t_chg) fe = fe + 5.0;
    oe = fe + 5.0 * (LAT - 1);
    at(t_chg);
    en = lvl;
    at(oe - 1.0);
    chk({tag, "_sync_before"}, sync_o, !lvl);
    at(oe + 1.0);
    chk({tag, "_sync_after"}, sync_o, lvl);
    chk({tag, "_pulse"}, lvl ? rise_o : fall_o, 1);
    chk({tag, "_other_pulse"}, lvl ? fall_o : rise_o, 0);
    at(oe + 6.0);
    chk({tag, "_pulse_gone"}, lvl ? rise_o : fall_o, 0);
    chk({tag, "_count"}, cnt_o, cnt_exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    int ridx;
    rst = 1'b1;
    en  = 1'b0;
    run_cmp = 1'b1;
    #1;
    chk("reset_sync", sync_o, 0);
    chk("reset_rise", rise_o, 0);
    chk("reset_fall", fall_o, 0);
    chk("reset_cnt",  cnt_o,  0);
    #4 rst = 1'b0;

    edge_check(213.0,  1'b1, "s1", 1);
    edge_check(613.0,  1'b0, "s2", 1);
    edge_check(2628.0, 1'b1, "s3", 2);
    at(2900.0);
    en = 1'b0;

    // Two-cycle glitch: filtered build must ignore it.
    at(3003.0);
    en = 1'b1;
    at(3013.0);
    en = 1'b0;
    at(3100.0);
    chk("s5_glitch_cnt",  cnt_o,  FILT_ON ? 2 : 3);
    chk("s5_glitch_sync", sync_o, 0);
    edge_check(3503.0, 1'b1, "s5", FILT_ON ? 3 : 4);
    at(3543.0);
    en = 1'b0;

    at(3700.0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
      end else begin
        en = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end

    // 17 rises on a 4-bit counter wrap to 1.
    @(negedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (17) begin
      repeat (10) @(negedge clk);
      en = 1'b1;
      repeat (10) @(negedge clk);
      en = 1'b0;
    end
    repeat (15) @(negedge clk);
    chk("s6_wrap_cnt", cnt_o, 1);

    // Reset asserted while the level is high clears everything at once.
    en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("s6_high_sync", sync_o, 1);
    chk("s6_high_cnt",  cnt_o,  2);
    rst = 1'b1;
    #0.5;
    chk("s6_async_sync", sync_o, 0);
    chk("s6_async_rise", rise_o, 0);
    chk("s6_async_fall", fall_o, 0);
    chk("s6_async_cnt",  cnt_o,  0);

    // command_en held high through reset: one rise, LAT cycles after release.
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    rst  = 1'b0;
    nr   = 0;
    ridx = -1;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      if (rise_o === 1'b1) begin
        nr++;
        ridx = c;
      end
    end
    chk("s4_rise_count", nr,   1);
    chk("s4_rise_cycle", ridx, LAT);
    chk("s4_cnt",        cnt_o, 1);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
